// File: rtl/exe_stage_core_pkg.sv
// rtl/exe_stage_core_pkg.sv - shared widths, alu_op bit indices and bus layouts for the execute stage
package exe_stage_core_pkg;

  localparam int XLEN            = 64;
  localparam int DS_TO_ES_BUS_WD = 280;
  localparam int ES_TO_MS_BUS_WD = 135;
  localparam int ALU_OP_WD       = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // Field order is MSB first, so the struct doubles as the bit-offset map of the decode bundle.
  typedef struct packed {
    logic                 res_is_word;
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_4;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic [XLEN-1:0]      pc;
  } ds_to_es_t;

  typedef struct packed {
    logic            load_op;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/exe_alu.sv
// rtl/exe_alu.sv - combinational 64-bit ALU with one-hot op select and word-result mode
module exe_alu
  import exe_stage_core_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] i_alu_op,
  input  logic [XLEN-1:0]      i_src1,
  input  logic [XLEN-1:0]      i_src2,
  input  logic                 i_res_is_word,
  output logic [XLEN-1:0]      o_result
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_srl_src;
  logic [XLEN-1:0] w_sra_src;
  logic [XLEN-1:0] w_add;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_slt;
  logic [XLEN-1:0] w_sltu;
  logic [XLEN-1:0] w_sll;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_raw;

  assign w_shamt   = i_res_is_word ? {1'b0, i_src2[4:0]} : i_src2[5:0];
  assign w_srl_src = i_res_is_word ? {32'd0, i_src1[31:0]} : i_src1;
  assign w_sra_src = i_res_is_word ? {{32{i_src1[31]}}, i_src1[31:0]} : i_src1;

  assign w_add  = i_src1 + i_src2;
  assign w_sub  = i_src1 - i_src2;
  assign w_slt  = {63'd0, $signed(i_src1) < $signed(i_src2)};
  assign w_sltu = {63'd0, i_src1 < i_src2};
  assign w_sll  = i_src1 << w_shamt;
  assign w_srl  = w_srl_src >> w_shamt;
  // Kept in its own assign so the arithmetic shift is not turned unsigned by the OR tree below.
  assign w_sra  = $signed(w_sra_src) >>> w_shamt;

  always_comb begin
    w_raw = '0;
    if (i_alu_op[ALU_ADD])  w_raw = w_raw | w_add;
    if (i_alu_op[ALU_SUB])  w_raw = w_raw | w_sub;
    if (i_alu_op[ALU_SLT])  w_raw = w_raw | w_slt;
    if (i_alu_op[ALU_SLTU]) w_raw = w_raw | w_sltu;
    if (i_alu_op[ALU_AND])  w_raw = w_raw | (i_src1 & i_src2);
    if (i_alu_op[ALU_NOR])  w_raw = w_raw | ~(i_src1 | i_src2);
    if (i_alu_op[ALU_OR])   w_raw = w_raw | (i_src1 | i_src2);
    if (i_alu_op[ALU_XOR])  w_raw = w_raw | (i_src1 ^ i_src2);
    if (i_alu_op[ALU_SLL])  w_raw = w_raw | w_sll;
    if (i_alu_op[ALU_SRL])  w_raw = w_raw | w_srl;
    if (i_alu_op[ALU_SRA])  w_raw = w_raw | w_sra;
    if (i_alu_op[ALU_LUI])  w_raw = w_raw | i_src2;
  end

  assign o_result = i_res_is_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;

endmodule

// File: rtl/exe_stage_core.sv
// rtl/exe_stage_core.sv - execute stage: decode-bundle latch, operand select, ALU and data-SRAM request
module exe_stage_core
  import exe_stage_core_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic                       data_sram_wen,
  output logic [XLEN-1:0]            data_sram_addr,
  output logic [XLEN-1:0]            data_sram_wdata,
  output logic [XLEN-1:0]            debug_rs1,
  output logic [XLEN-1:0]            debug_rs2,
  output logic [XLEN-1:0]            debug_es_pc,
  output logic [4:0]                 debug_es_dest,
  output logic [XLEN-1:0]            debug_es_alu_result,
  output logic [ALU_OP_WD-1:0]       debug_es_alu_op,
  output logic [XLEN-1:0]            debug_es_alu_src1,
  output logic [XLEN-1:0]            debug_es_alu_src2
);

  logic            r_es_valid;
  ds_to_es_t       r_bus;
  logic            w_es_ready_go;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [XLEN-1:0] w_alu_result;
  es_to_ms_t       w_es_to_ms;

  assign w_es_ready_go  = 1'b1;
  assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_es_ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_es_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (es_allowin) r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) r_bus <= ds_to_es_t'(ds_to_es_bus);
    end
  end

  // Immediate wins over the constant 4 when decode sets both.
  assign w_src1 = r_bus.src1_is_pc  ? r_bus.pc  : r_bus.rs1_value;
  assign w_src2 = r_bus.src2_is_imm ? r_bus.imm :
                  r_bus.src2_is_4   ? 64'd4     : r_bus.rs2_value;

  exe_alu u_exe_alu (
    .i_alu_op      (r_bus.alu_op),
    .i_src1        (w_src1),
    .i_src2        (w_src2),
    .i_res_is_word (r_bus.res_is_word),
    .o_result      (w_alu_result)
  );

  assign w_es_to_ms = '{load_op:    r_bus.load_op,
                        gr_we:      r_bus.gr_we,
                        dest:       r_bus.dest,
                        alu_result: w_alu_result,
                        pc:         r_bus.pc};
  assign es_to_ms_bus = w_es_to_ms;

  assign data_sram_en    = r_es_valid && (r_bus.load_op || r_bus.mem_we);
  assign data_sram_wen   = r_es_valid && r_bus.mem_we;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = r_bus.rs2_value;

  assign debug_rs1           = r_bus.rs1_value;
  assign debug_rs2           = r_bus.rs2_value;
  assign debug_es_pc         = r_bus.pc;
  assign debug_es_dest       = r_bus.dest;
  assign debug_es_alu_result = w_alu_result;
  assign debug_es_alu_op     = r_bus.alu_op;
  assign debug_es_alu_src1   = w_src1;
  assign debug_es_alu_src2   = w_src2;

endmodule

// File: tb/tb_exe_stage_core.sv
// tb/tb_exe_stage_core.sv - scoreboard bench for exe_stage_core with directed hand-computed vectors
module tb_exe_stage_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [279:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic         data_sram_en;
  logic         data_sram_wen;
  logic [63:0]  data_sram_addr;
  logic [63:0]  data_sram_wdata;
  logic [63:0]  debug_rs1;
  logic [63:0]  debug_rs2;
  logic [63:0]  debug_es_pc;
  logic [4:0]   debug_es_dest;
  logic [63:0]  debug_es_alu_result;
  logic [11:0]  debug_es_alu_op;
  logic [63:0]  debug_es_alu_src1;
  logic [63:0]  debug_es_alu_src2;

  exe_stage_core dut (
    .clk                 (clk),
    .reset               (reset),
    .ms_allowin          (ms_allowin),
    .es_allowin          (es_allowin),
    .ds_to_es_valid      (ds_to_es_valid),
    .ds_to_es_bus        (ds_to_es_bus),
    .es_to_ms_valid      (es_to_ms_valid),
    .es_to_ms_bus        (es_to_ms_bus),
    .data_sram_en        (data_sram_en),
    .data_sram_wen       (data_sram_wen),
    .data_sram_addr      (data_sram_addr),
    .data_sram_wdata     (data_sram_wdata),
    .debug_rs1           (debug_rs1),
    .debug_rs2           (debug_rs2),
    .debug_es_pc         (debug_es_pc),
    .debug_es_dest       (debug_es_dest),
    .debug_es_alu_result (debug_es_alu_result),
    .debug_es_alu_op     (debug_es_alu_op),
    .debug_es_alu_src1   (debug_es_alu_src1),
    .debug_es_alu_src2   (debug_es_alu_src2)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_NOR  = 12'h020;
  localparam logic [11:0] OP_OR   = 12'h040;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SLL  = 12'h100;
  localparam logic [11:0] OP_SRL  = 12'h200;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  typedef struct {
    logic [134:0] bus;
    logic         en;
    logic         wen;
    logic [63:0]  addr;
    logic [63:0]  wdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [279:0] mk(input logic w, input logic [11:0] op, input logic ld,
                                      input logic s1pc, input logic s2imm, input logic s24,
                                      input logic grwe, input logic mwe, input logic [4:0] dest,
                                      input logic [63:0] imm, input logic [63:0] rs1,
                                      input logic [63:0] rs2, input logic [63:0] pc);
    return {w, op, ld, s1pc, s2imm, s24, grwe, mwe, dest, imm, rs1, rs2, pc};
  endfunction

  // Push the expected ms-side view, then hold the bundle valid until es accepts it.
  task automatic issue(input logic [279:0] b, input logic [63:0] result);
    exp_t e;
    int   k;
    e.bus   = {b[266], b[262], b[260:256], result, b[63:0]};
    e.en    = b[266] | b[261];
    e.wen   = b[261];
    e.addr  = result;
    e.wdata = b[127:64];
    q.push_back(e);
    ds_to_es_bus   = b;
    ds_to_es_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (es_allowin) break;
    end
    if (k == 50) check("issue_timeout", 192'(es_allowin), 192'(1'b1));
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && es_to_ms_valid && ms_allowin) begin
        check("output_expected", 192'(q.size() != 0), 192'(1'b1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("es_to_ms_bus", 192'(es_to_ms_bus), 192'(e.bus));
          check("sram_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                {e.en, e.wen, e.addr, e.wdata});
        end
      end
    end
  end

  initial begin : stimulus
    reset          = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {es_allowin, es_to_ms_valid, data_sram_en, data_sram_wen},
          192'(4'b1000));
    check("reset_bus", 192'(es_to_ms_bus), 192'(0));
    check("reset_addr_wdata", {data_sram_addr, data_sram_wdata}, 192'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    issue(mk(0, OP_ADD, 0, 1, 0, 0, 1, 0, 5'd2, 64'd20, 64'd0, 64'd5, 64'd1), 64'd6);
    issue(mk(1, OP_ADD, 0, 1, 0, 0, 1, 0, 5'd2, 64'd20, 64'd0, 64'd3, 64'd1), 64'd4);
    issue(mk(1, OP_SUB, 0, 0, 0, 0, 1, 0, 5'd3, 64'd0, 64'd0, 64'd1, 64'h40),
          64'hFFFF_FFFF_FFFF_FFFF);
    issue(mk(0, OP_ADD, 0, 0, 1, 0, 0, 1, 5'd0, 64'd8, 64'h100, 64'hAB, 64'h44), 64'h108);
    issue(mk(0, OP_ADD, 1, 0, 1, 0, 1, 0, 5'd9, 64'hFFFF_FFFF_FFFF_FFF8, 64'h2000, 64'h55,
             64'h48), 64'h1FF8);
    issue(mk(0, OP_SRA, 0, 0, 0, 0, 1, 0, 5'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h4C),
          64'hFFFF_FFFF_FFFF_FFFC);
    issue(mk(0, OP_SLTU, 0, 0, 0, 0, 1, 0, 5'd5, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h50),
          64'd1);
    issue(mk(0, OP_SLT, 0, 0, 0, 0, 1, 0, 5'd6, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h54),
          64'd0);
    issue(mk(0, OP_ADD, 0, 1, 1, 1, 1, 0, 5'd1, 64'h10, 64'd0, 64'd0, 64'h1000), 64'h1010);
    issue(mk(0, OP_ADD, 0, 1, 0, 1, 1, 0, 5'd1, 64'h10, 64'd0, 64'd0, 64'h1000), 64'h1004);
    issue(mk(0, 12'h000, 0, 0, 0, 0, 1, 0, 5'd7, 64'd0, 64'h1234, 64'h5678, 64'h58), 64'd0);
    issue(mk(0, OP_LUI, 0, 0, 1, 0, 1, 0, 5'd8, 64'hABCD_E000, 64'h77, 64'd0, 64'h5C),
          64'hABCD_E000);
    issue(mk(1, OP_SRL, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h60),
          64'h0800_0000);
    issue(mk(0, OP_SLL, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'd1, 64'd63, 64'h64),
          64'h8000_0000_0000_0000);
    issue(mk(1, OP_SLL, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'd1, 64'h3F, 64'h68),
          64'hFFFF_FFFF_8000_0000);
    issue(mk(1, OP_SRA, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'h8000_0000, 64'd4, 64'h6C),
          64'hFFFF_FFFF_F800_0000);
    issue(mk(0, OP_NOR, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'd0, 64'hFF, 64'h70),
          64'hFFFF_FFFF_FFFF_FF00);
    issue(mk(0, OP_AND, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'hF0F0, 64'hFF00, 64'h74), 64'hF000);
    issue(mk(0, OP_OR, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'hF0, 64'h0F, 64'h78), 64'hFF);
    issue(mk(0, OP_XOR, 0, 0, 0, 0, 1, 0, 5'd8, 64'd0, 64'hFF, 64'h0F, 64'h7C), 64'hF0);

    // Stall: hold instruction A in es while ds keeps offering changing bundles.
    issue(mk(0, OP_ADD, 0, 0, 0, 0, 1, 0, 5'd7, 64'd0, 64'd10, 64'd20, 64'h200), 64'd30);
    ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(0, OP_SUB, 0, 0, 0, 0, 1, 0, 5'd9, 64'd0, 64'(100 + i), 64'd1, 64'h300);
      @(negedge clk);
      check("stall_allowin", 192'(es_allowin), 192'(1'b0));
      check("stall_bus_frozen", 192'(es_to_ms_bus), 192'({1'b0, 1'b1, 5'd7, 64'd30, 64'h200}));
      check("stall_result_frozen", 192'(debug_es_alu_result), 192'(64'd30));
    end
    @(posedge clk);
    #1;
    ms_allowin = 1'b1;
    issue(mk(0, OP_SUB, 0, 0, 0, 0, 1, 0, 5'd9, 64'd0, 64'd102, 64'd1, 64'h300), 64'd101);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    check("drain_before_reset", 192'(q.size()), 192'(0));
    #1;

    // Mid-stream reset drops the in-flight instruction, so nothing is queued for it.
    ds_to_es_bus   = mk(0, OP_ADD, 1, 0, 0, 0, 1, 0, 5'd3, 64'd0, 64'd7, 64'd8, 64'h400);
    ds_to_es_valid = 1'b1;
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    check("pre_reset_valid", 192'(es_to_ms_valid), 192'(1'b1));
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", {es_to_ms_valid, data_sram_en, data_sram_wen, es_allowin},
          192'(4'b0001));
    check("mid_reset_bus", 192'(es_to_ms_bus), 192'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(mk(0, OP_ADD, 0, 0, 1, 0, 1, 0, 5'd4, 64'd5, 64'd6, 64'd0, 64'h500), 64'd11);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    check("queue_drained", 192'(q.size()), 192'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
